// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//   Writeback stage plus integer register file. Selects the writeback result
//   from the MEM/WB signals, commits it to the register array on the rising
//   clock edge, serves the two combinational decode read ports, and counts
//   committed writes for debug.
//
// Configuration macro:
//   REGFILE_BYPASS_EN - when defined, a read port whose address matches the
//                       write being committed this cycle returns ResultW
//                       directly (write-through). When undefined, reads see
//                       the array as of the last clock edge.
//
// Ports:
//   clock       in   system clock, rising-edge active
//   reset       in   synchronous active-high reset
//   controlW    in   [2] RegWriteW, [1:0] ResultSrcW
//   AluResultW  in   ALU result
//   ReadDataW   in   load data
//   PcPlus4W    in   link value
//   RdW         in   destination register
//   Rs1D/Rs2D   in   decode read addresses
//   Rd1D/Rd2D   out  decode read data (x0 always reads 0)
//   ResultW     out  selected writeback value (combinational)
//   WriteCount  out  committed writes to x1..x(NREGS-1), wraps
// -----------------------------------------------------------------------------
module writeback_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int CNTW  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0]      controlW,
  input  logic [XLEN-1:0] AluResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PcPlus4W,
  input  logic [AW-1:0]   RdW,
  input  logic [AW-1:0]   Rs1D,
  input  logic [AW-1:0]   Rs2D,
  output logic [XLEN-1:0] Rd1D,
  output logic [XLEN-1:0] Rd2D,
  output logic [XLEN-1:0] ResultW,
  output logic [CNTW-1:0] WriteCount
);

  logic            regwrite_s;
  logic [1:0]      result_src_s;
  logic [XLEN-1:0] result_s;
  logic            commit_s;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;

  assign regwrite_s   = controlW[2];
  assign result_src_s = controlW[1:0];

  // Writeback result mux; the reserved encoding falls back to the ALU result.
  always_comb begin
    case (result_src_s)
      2'b00:   result_s = AluResultW;
      2'b01:   result_s = ReadDataW;
      2'b10:   result_s = PcPlus4W;
      default: result_s = AluResultW;
    endcase
  end

  assign ResultW = result_s;

  // A write commits only when enabled, not aimed at x0 and not under reset.
  assign commit_s = regwrite_s && (RdW != {AW{1'b0}}) && !reset;

  // Next-state array and counter: one entry updated per committed write.
  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (commit_s) begin
      regs_d[RdW] = result_s;
      count_d     = count_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // State update; reset has priority so X on controlW cannot leak in.
  // Entry 0 is only ever cleared, so it synthesises to a constant.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
      count_q <= {CNTW{1'b0}};
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  assign WriteCount = count_q;

`ifdef REGFILE_BYPASS_EN
  // Read port 1 with write-through of the in-flight commit.
  always_comb begin
    if (Rs1D == {AW{1'b0}}) begin
      Rd1D = {XLEN{1'b0}};
    end else if (commit_s && (Rs1D == RdW)) begin
      Rd1D = result_s;
    end else begin
      Rd1D = regs_q[Rs1D];
    end
  end

  // Read port 2 with write-through of the in-flight commit.
  always_comb begin
    if (Rs2D == {AW{1'b0}}) begin
      Rd2D = {XLEN{1'b0}};
    end else if (commit_s && (Rs2D == RdW)) begin
      Rd2D = result_s;
    end else begin
      Rd2D = regs_q[Rs2D];
    end
  end
`else
  // Read port 1 from the committed array only.
  always_comb begin
    if (Rs1D == {AW{1'b0}}) begin
      Rd1D = {XLEN{1'b0}};
    end else begin
      Rd1D = regs_q[Rs1D];
    end
  end

  // Read port 2 from the committed array only.
  always_comb begin
    if (Rs2D == {AW{1'b0}}) begin
      Rd2D = {XLEN{1'b0}};
    end else begin
      Rd2D = regs_q[Rs2D];
    end
  end
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios followed by
// randomized traffic compared against a simple array/counter reference model.
// A second instance with a 4-bit counter exercises counter wrap-around.
module tb_writeback_regfile;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  controlW = 3'b000;
  logic [31:0] AluResultW = 32'h0;
  logic [31:0] ReadDataW = 32'h0;
  logic [31:0] PcPlus4W = 32'h0;
  logic [4:0]  RdW = 5'd0;
  logic [4:0]  Rs1D = 5'd0;
  logic [4:0]  Rs2D = 5'd0;
  logic [31:0] Rd1D, Rd2D, ResultW, WriteCount;
  logic [31:0] s_Rd1D, s_Rd2D, s_ResultW;
  logic [3:0]  s_WriteCount;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  always #5 clock = ~clock;

  writeback_regfile dut (
    .clock(clock), .reset(reset), .controlW(controlW),
    .AluResultW(AluResultW), .ReadDataW(ReadDataW), .PcPlus4W(PcPlus4W),
    .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Rd1D(Rd1D), .Rd2D(Rd2D), .ResultW(ResultW), .WriteCount(WriteCount)
  );

  writeback_regfile #(.CNTW(4)) dut_small (
    .clock(clock), .reset(reset), .controlW(controlW),
    .AluResultW(AluResultW), .ReadDataW(ReadDataW), .PcPlus4W(PcPlus4W),
    .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Rd1D(s_Rd1D), .Rd2D(s_Rd2D), .ResultW(s_ResultW), .WriteCount(s_WriteCount)
  );

  function automatic logic [31:0] m_result();
    if (controlW[1:0] == 2'b01) return ReadDataW;
    if (controlW[1:0] == 2'b10) return PcPlus4W;
    return AluResultW;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && controlW[2] && RdW != 5'd0 && rs == RdW) return m_result();
`endif
    return m_regs[rs];
  endfunction

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 32'h0;
    end else if (controlW[2] && RdW != 5'd0) begin
      m_regs[RdW] = m_result();
      m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    controlW = 3'bx1x;
    RdW = 5'd5;
    AluResultW = 32'hCAFEF00D;
    tick();
    tick();
    reset = 1'b0;
    controlW = 3'b000;
    for (int i = 0; i < 32; i++) begin
      Rs1D = 5'(i);
      Rs2D = 5'(31 - i);
      #1;
      checks++;
      if (Rd1D !== 32'h0 || Rd2D !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got rd1=%h rd2=%h exp 0", i, Rd1D, Rd2D);
      end
    end
    checks++;
    if (WriteCount !== 32'd0 || s_WriteCount !== 4'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d/%0d exp 0", WriteCount, s_WriteCount);
    end
  endtask

  task automatic test_result_select();
    controlW = 3'b100; AluResultW = 32'hDEADBEEF; ReadDataW = 32'h12345678;
    PcPlus4W = 32'h00000104; RdW = 5'd5;
    #1;
    checks++;
    if (ResultW !== 32'hDEADBEEF) begin
      errors++; $display("FAIL result_alu got=%h exp=deadbeef", ResultW);
    end
    controlW = 3'b111;
    #1;
    checks++;
    if (ResultW !== 32'hDEADBEEF) begin
      errors++; $display("FAIL result_reserved got=%h exp=deadbeef", ResultW);
    end
    controlW = 3'b100;
    tick();
    controlW = 3'b000; Rs1D = 5'd5;
    #1;
    checks++;
    if (Rd1D !== 32'hDEADBEEF || WriteCount !== 32'd1) begin
      errors++; $display("FAIL write_alu got=%h cnt=%0d exp=deadbeef cnt=1", Rd1D, WriteCount);
    end
    controlW = 3'b101; RdW = 5'd6;
    #1;
    checks++;
    if (ResultW !== 32'h12345678) begin
      errors++; $display("FAIL result_load got=%h exp=12345678", ResultW);
    end
    tick();
    controlW = 3'b110; RdW = 5'd1;
    #1;
    checks++;
    if (ResultW !== 32'h00000104) begin
      errors++; $display("FAIL result_link got=%h exp=00000104", ResultW);
    end
    tick();
    controlW = 3'b000; Rs1D = 5'd6; Rs2D = 5'd1;
    #1;
    checks++;
    if (Rd1D !== 32'h12345678 || Rd2D !== 32'h00000104 || WriteCount !== 32'd3) begin
      errors++;
      $display("FAIL write_load_link got=%h %h cnt=%0d exp=12345678 00000104 cnt=3", Rd1D, Rd2D, WriteCount);
    end
  endtask

  task automatic test_x0();
    controlW = 3'b100; RdW = 5'd0; AluResultW = 32'hFFFFFFFF;
    tick();
    controlW = 3'b000; Rs1D = 5'd0;
    #1;
    checks++;
    if (Rd1D !== 32'h0 || WriteCount !== 32'd3) begin
      errors++; $display("FAIL x0_write got=%h cnt=%0d exp=0 cnt=3", Rd1D, WriteCount);
    end
    controlW = 3'b000; RdW = 5'd7; AluResultW = 32'h77777777;
    tick();
    Rs1D = 5'd7;
    #1;
    checks++;
    if (Rd1D !== 32'h0 || WriteCount !== 32'd3) begin
      errors++; $display("FAIL bubble got=%h cnt=%0d exp=0 cnt=3", Rd1D, WriteCount);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] exp_now;
`ifdef REGFILE_BYPASS_EN
    exp_now = 32'hA5A5A5A5;
`else
    exp_now = 32'h0;
`endif
    controlW = 3'b100; RdW = 5'd9; AluResultW = 32'hA5A5A5A5;
    Rs1D = 5'd9; Rs2D = 5'd9;
    #1;
    checks++;
    if (Rd1D !== exp_now || Rd2D !== exp_now) begin
      errors++; $display("FAIL same_edge got=%h %h exp=%h", Rd1D, Rd2D, exp_now);
    end
    tick();
    controlW = 3'b000;
    #1;
    checks++;
    if (Rd1D !== 32'hA5A5A5A5 || Rd2D !== 32'hA5A5A5A5 || WriteCount !== 32'd4) begin
      errors++; $display("FAIL after_edge got=%h %h cnt=%0d exp=a5a5a5a5 cnt=4", Rd1D, Rd2D, WriteCount);
    end
  endtask

  task automatic test_reset_collision();
    controlW = 3'b100; RdW = 5'd3; AluResultW = 32'h11;
    tick();
    reset = 1'b1; AluResultW = 32'h22;
    tick();
    reset = 1'b0; controlW = 3'b000; Rs1D = 5'd3; Rs2D = 5'd9;
    #1;
    checks++;
    if (Rd1D !== 32'h0 || Rd2D !== 32'h0 || WriteCount !== 32'd0) begin
      errors++; $display("FAIL reset_collision got=%h %h cnt=%0d exp=0 0 cnt=0", Rd1D, Rd2D, WriteCount);
    end
    controlW = 3'b100; AluResultW = 32'h33;
    tick();
    controlW = 3'b000;
    #1;
    checks++;
    if (Rd1D !== 32'h33 || WriteCount !== 32'd1) begin
      errors++; $display("FAIL post_reset_write got=%h cnt=%0d exp=33 cnt=1", Rd1D, WriteCount);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      controlW = 3'b100; RdW = 5'($urandom_range(31, 1)); AluResultW = $urandom;
      tick();
    end
    controlW = 3'b000;
    #1;
    checks++;
    if (s_WriteCount !== 4'hF || WriteCount !== 32'd15) begin
      errors++; $display("FAIL wrap_pre got=%0d/%0d exp=15/15", s_WriteCount, WriteCount);
    end
    controlW = 3'b100; RdW = 5'd2;
    tick();
    controlW = 3'b000;
    #1;
    checks++;
    if (s_WriteCount !== 4'h0 || WriteCount !== 32'd16) begin
      errors++; $display("FAIL wrap got=%0d/%0d exp=0/16", s_WriteCount, WriteCount);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(39, 0) == 0);
      controlW = 3'($urandom);
      AluResultW = $urandom; ReadDataW = $urandom; PcPlus4W = $urandom;
      RdW = 5'($urandom);
      Rs1D = 5'($urandom);
      Rs2D = ($urandom_range(1, 0) == 1) ? RdW : 5'($urandom);
      #1;
      checks++;
      if (ResultW !== m_result() || Rd1D !== m_read(Rs1D) || Rd2D !== m_read(Rs2D) ||
          WriteCount !== m_cnt || s_WriteCount !== m_cnt[3:0]) begin
        errors++;
        $display("FAIL random n=%0d got res=%h rd1=%h rd2=%h cnt=%0d scnt=%0d exp res=%h rd1=%h rd2=%h cnt=%0d",
                 n, ResultW, Rd1D, Rd2D, WriteCount, s_WriteCount,
                 m_result(), m_read(Rs1D), m_read(Rs2D), m_cnt);
      end
      tick();
    end
    reset = 1'b0;
    controlW = 3'b000;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 32'h0;
    test_reset();
    test_result_select();
    test_x0();
    test_same_edge();
    test_reset_collision();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
